mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//  Parametrised load/store unit for the MEM stage; successor to the combinational MEM access path.
//  Accepts one load or store per request handshake and drives a single-outstanding AXI-lite-style bus master.
//  Aligns byte lanes by address offset, sign/zero-extends load data, and splits RAM from MMIO by address.
//  Flags misaligned accesses and bus errors. Passes non-memory results through to mem_wb.
// PARAMETERS
//  XLEN      64             data width; 32 or 64
//  AW        64             address width
//  MMIO_BASE 64'hA000_0000  addresses >= MMIO_BASE are MMIO (mmio_o=1); below are RAM
//  TIMEOUT   255            cycles waiting for R/B before timeout fault; 0 disables the timeout
// PORTS
//  clk          in  1       clock
//  rst          in  1       asynchronous reset, active-low
//  req_valid_i  in  1       request valid from ex_mem
//  req_ready_o  out 1       unit can accept a request (FSM in IDLE)
//  req_load_i   in  1       load
//  req_store_i  in  1       store; load and store both set = illegal, treated as a load
//  req_addr_i   in  AW      byte address
//  req_size_i   in  2       0=B, 1=H, 2=W, 3=D (D only legal when XLEN=64)
//  req_uns_i    in  1       zero-extend load data
//  req_wdata_i  in  XLEN    store data, LSB-aligned
//  rd_waddr_i   in  5       destination register
//  reg_wen_i    in  1       register write enable
//  rd_wdata_i   in  XLEN    ALU result for non-memory requests
//  ar_valid_o   out 1 / ar_ready_i in 1 / ar_addr_o out AW      read address channel
//  r_valid_i    in  1 / r_data_i in XLEN / r_resp_i in 2        read data channel (always ready)
//  aw_valid_o   out 1 / aw_ready_i in 1 / aw_addr_o out AW      write address and data, issued together
//  w_data_o     out XLEN / w_strb_o out XLEN/8                  lane-shifted write data and byte strobes
//  b_valid_i    in  1 / b_resp_i in 2                           write response (always ready)
//  mmio_o       out 1       current bus access targets MMIO
//  wb_valid_o   out 1       one-cycle result pulse to mem_wb
//  rd_wdata_o   out XLEN / rd_waddr_o out 5 / reg_wen_o out 1    writeback fields
//  stall_o      out 1       stall upstream stages (FSM not in IDLE, or a memory request is presented)
//  fault_o      out 1       with wb_valid_o: misaligned, bus error or timeout; reg_wen_o forced 0
// BEHAVIOUR
//  - Reset: FSM=IDLE; req_ready_o=1; every other output and register is 0.
//  - FSM states: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
//  - IDLE, on req_valid_i:
//    - Neither load nor store: capture the request; go to DONE; rd_wdata_o = rd_wdata_i.
//    - Misaligned (addr mod 2^size != 0): go to DONE with fault_o=1; no bus access is made.
//    - Otherwise: load -> RADDR, store -> WADDR.
//  - RADDR: ar_valid_o held until ar_ready_i, then go to RDATA.
//  - RDATA: on r_valid_i, go to DONE.
//    - Data = r_data_i >> (8*addr[off]), off = log2(XLEN/8) LSBs; then sign/zero-extend per size and req_uns_i.
//  - WADDR: aw_valid_o held until aw_ready_i, then go to WRESP.
//    - w_data_o = wdata << (8*off); w_strb_o = ((1<<(1<<size))-1) << off.
//  - WRESP: on b_valid_i, go to DONE.
//  - DONE: wb_valid_o=1 for exactly one cycle, then go to IDLE.
//    - Stores and faults assert reg_wen_o=0.
//  - Bus fault: r_resp_i/b_resp_i != 0 sets fault_o=1; read data is discarded (rd_wdata_o=0).
//  - Timeout: wait counter counts cycles in RDATA/WRESP; at TIMEOUT, go to DONE with fault_o=1.
//    - A late R/B response arriving in IDLE is ignored.
//  - Latency: best case 4 cycles request->wb_valid_o (accept, addr, resp, DONE); pass-through is 2.
//  - Bus outputs, addresses and mmio_o are registered.
//    - Valid signals never drop before ready.
//    - Address and data are stable while valid is high.
//  - Reset mid-transaction returns the FSM to IDLE immediately; the in-flight result is lost.
//  - Back-to-back: a new request is accepted in the cycle after DONE (IDLE); no bubble beyond that.
//  - mmio_o compare is unsigned over the full AW bits; address MMIO_BASE-1 gives mmio_o=0.
// STRUCTURE
//  - Shared package lsu_pkg:
//    - FSM state enum; size encodings (SZ_B/H/W/D); resp codes (OKAY=0, SLVERR=2).
//    - Function lsu_align_load(data, off, size, uns).
//    - Function lsu_strb(off, size).
//  - One sub-module, lsu_load_align: combinational shift and extend, reused by the bus-facing cache later.
// TESTING
//  - LB at 0x8000_0003, r_data=0x..._80_000000, uns=0 -> rd_wdata_o=0xFFFF_FFFF_FFFF_FF80, wb in 4 cycles.
//  - SH 0xBEEF at 0x8000_0006 -> w_data_o[63:48]=0xBEEF, w_strb_o=8'hC0, reg_wen_o=0.
//  - LW at 0x8000_0002 -> fault_o=1, no ar_valid_o ever, wb_valid_o in 2 cycles.
//  - LD at 0xA000_0048 -> mmio_o=1; ar_ready_i held low 5 cycles -> ar_valid_o and ar_addr_o stable throughout.
//  - r_resp=2'b10 -> fault_o=1, reg_wen_o=0; no R response with TIMEOUT=8 -> fault after 8 cycles in RDATA.
//  - rst low during WRESP -> all outputs 0, req_ready_o=1 next cycle; a late b_valid_i is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
    function automatic logic [63:0] lsu_align_load(input logic [63:0] data,
                                                   input logic [2:0]  off,
                                                   input logic [1:0]  size,
                                                   input logic        uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = data >> {off, 3'b000};
        case (size)
            SZ_B:    res = {{56{~uns & sh[7]}},  sh[7:0]};
            SZ_H:    res = {{48{~uns & sh[15]}}, sh[15:0]};
            SZ_W:    res = {{32{~uns & sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Byte-enable mask for an access of 2^size bytes starting at lane off.
    function automatic logic [7:0] lsu_strb(input logic [2:0] off,
                                            input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // True when the address is not a multiple of the access size; a
    // doubleword on a 32-bit datapath is also rejected here.
    function automatic logic lsu_misaligned(input logic [2:0] lo,
                                            input logic [1:0] size,
                                            input logic       allow_d);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo[1:0];
            SZ_D:    bad = ~allow_d | (|lo);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data lane shift and sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OFFW = 3
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    output logic [XLEN-1:0] data_o
);

    logic [63:0] wide_s;

    // Widen to the package helper's 64-bit datapath and narrow the result back.
    always_comb begin
        wide_s = lsu_align_load(64'(data_i), 3'(off_i), size_i, uns_i);
        data_o = wide_s[XLEN-1:0];
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding AXI-lite-style bus master.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter int          AW        = 64,
    parameter logic [63:0] MMIO_BASE = 64'hA000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_load_i,
    input  logic              req_store_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_uns_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        rd_waddr_i,
    input  logic              reg_wen_i,
    input  logic [XLEN-1:0]   rd_wdata_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [AW-1:0]     ar_addr_o,
    input  logic              r_valid_i,
    input  logic [XLEN-1:0]   r_data_i,
    input  logic [1:0]        r_resp_i,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [AW-1:0]     aw_addr_o,
    output logic [XLEN-1:0]   w_data_o,
    output logic [XLEN/8-1:0] w_strb_o,
    input  logic              b_valid_i,
    input  logic [1:0]        b_resp_i,
    output logic              mmio_o,
    output logic              wb_valid_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic [4:0]        rd_waddr_o,
    output logic              reg_wen_o,
    output logic              stall_o,
    output logic              fault_o
);

    localparam int SW    = XLEN / 8;
    localparam int OFFW  = $clog2(SW);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW-1:0]    MMIO_BASE_A = MMIO_BASE[AW-1:0];

    lsu_state_e        state_q, state_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [4:0]        waddr_q, waddr_d;
    logic              wen_q, wen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ar_valid_q, ar_valid_d;
    logic [AW-1:0]     ar_addr_q, ar_addr_d;
    logic              aw_valid_q, aw_valid_d;
    logic [AW-1:0]     aw_addr_q, aw_addr_d;
    logic [XLEN-1:0]   w_data_q, w_data_d;
    logic [SW-1:0]     w_strb_q, w_strb_d;
    logic              mmio_q, mmio_d;
    logic              wb_valid_q, wb_valid_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rd_wdata_q, rd_wdata_d;
    logic [4:0]        rd_waddr_q, rd_waddr_d;
    logic              reg_wen_q, reg_wen_d;

    logic [XLEN-1:0]   load_data_s;
    logic [XLEN-1:0]   wshift_s;
    logic [7:0]        strb_full_s;
    logic              misal_s;
    logic              mmio_s;
    logic              timeout_hit_s;

    lsu_load_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
        .data_i (r_data_i),
        .off_i  (off_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .data_o (load_data_s)
    );

    // Request-side decode: lane-shifted store data, strobes, alignment and region.
    always_comb begin
        wshift_s      = req_wdata_i << {req_addr_i[OFFW-1:0], 3'b000};
        strb_full_s   = lsu_strb(3'(req_addr_i[OFFW-1:0]), req_size_i);
        misal_s       = lsu_misaligned(req_addr_i[2:0], req_size_i, XLEN == 64);
        mmio_s        = (req_addr_i >= MMIO_BASE_A);
        timeout_hit_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        waddr_d    = waddr_q;
        wen_d      = wen_q;
        cnt_d      = cnt_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        mmio_d     = mmio_q;
        wb_valid_d = 1'b0;
        fault_d    = 1'b0;
        rd_wdata_d = rd_wdata_q;
        rd_waddr_d = rd_waddr_q;
        reg_wen_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    off_d   = req_addr_i[OFFW-1:0];
                    size_d  = req_size_i;
                    uns_d   = req_uns_i;
                    waddr_d = rd_waddr_i;
                    wen_d   = reg_wen_i;
                    if (!req_load_i && !req_store_i) begin
                        state_d    = ST_DONE;
                        wb_valid_d = 1'b1;
                        rd_wdata_d = rd_wdata_i;
                        rd_waddr_d = rd_waddr_i;
                        reg_wen_d  = reg_wen_i;
                    end else if (misal_s) begin
                        state_d    = ST_DONE;
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        rd_wdata_d = '0;
                        rd_waddr_d = rd_waddr_i;
                    end else if (req_load_i) begin
                        // Load wins when both load and store are set.
                        state_d    = ST_RADDR;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = req_addr_i;
                        mmio_d     = mmio_s;
                    end else begin
                        state_d    = ST_WADDR;
                        aw_valid_d = 1'b1;
                        aw_addr_d  = req_addr_i;
                        w_data_d   = wshift_s;
                        w_strb_d   = strb_full_s[SW-1:0];
                        mmio_d     = mmio_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_RDATA;
                end else begin
                    state_d = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (r_valid_i) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    mmio_d     = 1'b0;
                    rd_waddr_d = waddr_q;
                    if (r_resp_i != RESP_OKAY) begin
                        fault_d    = 1'b1;
                        rd_wdata_d = '0;
                    end else begin
                        rd_wdata_d = load_data_s;
                        reg_wen_d  = wen_q;
                    end
                end else if (timeout_hit_s) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    mmio_d     = 1'b0;
                    rd_wdata_d = '0;
                    rd_waddr_d = waddr_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WADDR: begin
                if (aw_ready_i) begin
                    aw_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_WRESP;
                end else begin
                    state_d = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (b_valid_i) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    fault_d    = (b_resp_i != RESP_OKAY);
                    mmio_d     = 1'b0;
                    rd_wdata_d = '0;
                    rd_waddr_d = waddr_q;
                end else if (timeout_hit_s) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    mmio_d     = 1'b0;
                    rd_wdata_d = '0;
                    rd_waddr_d = waddr_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; async reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            waddr_q    <= 5'd0;
            wen_q      <= 1'b0;
            cnt_q      <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            mmio_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            rd_wdata_q <= '0;
            rd_waddr_q <= 5'd0;
            reg_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            waddr_q    <= waddr_d;
            wen_q      <= wen_d;
            cnt_q      <= cnt_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            mmio_q     <= mmio_d;
            wb_valid_q <= wb_valid_d;
            fault_q    <= fault_d;
            rd_wdata_q <= rd_wdata_d;
            rd_waddr_q <= rd_waddr_d;
            reg_wen_q  <= reg_wen_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign stall_o     = (state_q != ST_IDLE) | (req_valid_i & (req_load_i | req_store_i));
    assign ar_valid_o  = ar_valid_q;
    assign ar_addr_o   = ar_addr_q;
    assign aw_valid_o  = aw_valid_q;
    assign aw_addr_o   = aw_addr_q;
    assign w_data_o    = w_data_q;
    assign w_strb_o    = w_strb_q;
    assign mmio_o      = mmio_q;
    assign wb_valid_o  = wb_valid_q;
    assign fault_o     = fault_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign reg_wen_o   = reg_wen_q;

endmodule
